// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
//   Source-domain end of a toggle req/ack multi-bit CDC handshake. A word
//   accepted on the valid/ready port is held on o_data while o_req toggles.
//   The far domain's toggled ack is brought in through a NUM_SYNC flop chain
//   (clamped to 1..3). The transfer completes when the synchronized ack
//   matches o_req.
//
//   Optional build macro: CDC_TX_TIMEOUT_EN
//     defined   -> WAIT_ACK watchdog that sets a sticky err_timeout flag
//     undefined -> no watchdog logic, err_timeout tied low

module cdc_handshake_tx #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned NUM_SYNC       = 2,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 s_ready,
  output logic                 o_req,
  output logic [WIDTH-1:0]     o_data,
  input  logic                 i_ack,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] xfer_cnt,
  input  logic                 err_clr,
  output logic                 err_spurious,
  output logic                 err_timeout
);

  // Effective synchronizer depth after clamping to the supported range.
  localparam int unsigned SYNC_N = (NUM_SYNC < 1) ? 1 :
                                   ((NUM_SYNC > 3) ? 3 : NUM_SYNC);

  // A watchdog shorter than two cycles cannot distinguish launch from expiry.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("cdc_handshake_tx: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_t;

  state_t state_q;
  state_t state_d;

  // Ack synchronizer and its one-cycle-delayed copy.
  logic [SYNC_N-1:0] ack_sync_q;
  logic              ack_s;
  logic              ack_s_d_q;

  // Transfer-side registers.
  logic                 req_q;
  logic [WIDTH-1:0]     data_q;
  logic                 ready_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 spur_q;

  // Decoded events.
  logic accept;
  logic ack_match;
  logic ack_edge;

  assign ack_s     = ack_sync_q[SYNC_N-1];
  assign accept    = (state_q == IDLE) && ready_q && s_valid;
  assign ack_match = (state_q == WAIT_ACK) && (ack_s == req_q);
  assign ack_edge  = ack_s ^ ack_s_d_q;

  // Synchronize the far-domain ack and keep a delayed copy for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_sync_q <= '0;
      ack_s_d_q  <= 1'b0;
    end else begin
      ack_sync_q[0] <= i_ack;
      for (int unsigned i = 1; i < SYNC_N; i++) begin
        ack_sync_q[i] <= ack_sync_q[i-1];
      end
      ack_s_d_q <= ack_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: launch on accept, return to IDLE once the ack matches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == req_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy for the whole wait, done in the cycle the ack matches.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      WAIT_ACK: begin
        busy = 1'b1;
        done = (ack_s == req_q);
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Ready is registered from the next state so it is low in the reset cycle
  // and rises in the cycle after done.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_d == IDLE);
    end
  end

  // Capture the word and toggle the request on accept; frozen otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q  <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      req_q  <= ~req_q;
      data_q <= s_data;
    end
  end

  // Count completed transfers, wrapping naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (ack_match) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Sticky spurious-ack flag; a clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (reset) begin
      spur_q <= 1'b0;
    end else if (err_clr) begin
      spur_q <= 1'b0;
    end else if ((state_q == IDLE) && ack_edge) begin
      spur_q <= 1'b1;
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_HOLD = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_q;
  logic            to_fire;

  assign to_fire = (state_q == WAIT_ACK) && !ack_match && (to_cnt_q == TO_LAST);

  // Watchdog counter: cleared on launch, parks one past the trip value so
  // the flag can only be raised once per transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (accept) begin
      to_cnt_q <= '0;
    end else if ((state_q == WAIT_ACK) && (to_cnt_q != TO_HOLD)) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // Sticky timeout flag; a clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_q <= 1'b0;
    end else if (err_clr) begin
      to_q <= 1'b0;
    end else if (to_fire) begin
      to_q <= 1'b1;
    end
  end

  assign err_timeout = to_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign s_ready      = ready_q;
  assign o_req        = req_q;
  assign o_data       = data_q;
  assign xfer_cnt     = cnt_q;
  assign err_spurious = spur_q;

endmodule
